// File: rtl/sw_debouncer.sv
// -----------------------------------------------------------------------------
// sw_debouncer
//
// Conditions NB_SW raw mechanical switch inputs. Each bit is brought into the
// clock domain through a two-flop synchronizer. A per-bit STABLE/COUNT state
// machine then accepts a new level only after the synchronized input has held
// it long enough. Accepted changes update o_sw and raise a one-cycle rise or
// fall pulse. Every output comes straight from a register.
//
// Parameters
//   NB_SW     number of switches handled in parallel
//   NB_COUNT  width of each per-switch debounce counter
//   DB_LIMIT  stable cycles required before a change is accepted (2..2^NB_COUNT)
//
// Ports
//   clock     system clock, rising-edge active
//   i_reset   asynchronous active-low reset
//   i_sw      raw, asynchronous, bouncing switch levels
//   o_sw      debounced switch levels
//   o_rise    one-cycle pulse per bit on an accepted 0->1 change
//   o_fall    one-cycle pulse per bit on an accepted 1->0 change
//   o_change  high in the same cycle as any o_rise/o_fall bit
// -----------------------------------------------------------------------------
module sw_debouncer #(
   parameter int NB_SW    = 4,
   parameter int NB_COUNT = 14,
   parameter int DB_LIMIT = 10000
) (
   input  logic             clock,
   input  logic             i_reset,
   input  logic [NB_SW-1:0] i_sw,
   output logic [NB_SW-1:0] o_sw,
   output logic [NB_SW-1:0] o_rise,
   output logic [NB_SW-1:0] o_fall,
   output logic             o_change
);

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_COUNT  = 1'b1
   } state_t;

   // Terminal count: the counter never goes past this value, so it cannot wrap.
   localparam logic [NB_COUNT-1:0] CNT_LAST = NB_COUNT'(DB_LIMIT - 1);

   logic [NB_SW-1:0] sync_s1_q;
   logic [NB_SW-1:0] sync_s2_q;
   logic [NB_SW-1:0] sw_q;
   logic [NB_SW-1:0] sw_d;
   logic [NB_SW-1:0] rise_q;
   logic [NB_SW-1:0] rise_d;
   logic [NB_SW-1:0] fall_q;
   logic [NB_SW-1:0] fall_d;
   logic             change_q;
   logic             change_d;

   // Synchronizer and output registers.
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         sync_s1_q <= '0;
         sync_s2_q <= '0;
         sw_q      <= '0;
         rise_q    <= '0;
         fall_q    <= '0;
         change_q  <= 1'b0;
      end else begin
         sync_s1_q <= i_sw;
         sync_s2_q <= sync_s1_q;
         sw_q      <= sw_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         change_q  <= change_d;
      end
   end

   // o_change is registered from the same next-state pulses, so it lines up
   // with o_rise/o_fall rather than trailing them by a cycle.
   always_comb begin
      change_d = |(rise_d | fall_d);
   end

   generate
      for (genvar gi = 0; gi < NB_SW; gi++) begin : g_bit
         state_t              state_q;
         state_t              state_d;
         logic [NB_COUNT-1:0] cnt_q;
         logic [NB_COUNT-1:0] cnt_d;
         logic                sw_bit_d;
         logic                rise_bit_d;
         logic                fall_bit_d;

         always_comb begin
            state_d    = state_q;
            cnt_d      = cnt_q;
            sw_bit_d   = sw_q[gi];
            rise_bit_d = 1'b0;
            fall_bit_d = 1'b0;
            case (state_q)
               ST_STABLE: begin
                  if (sync_s2_q[gi] != sw_q[gi]) begin
                     state_d = ST_COUNT;
                     cnt_d   = '0;
                  end
               end
               ST_COUNT: begin
                  if (sync_s2_q[gi] == sw_q[gi]) begin
                     // Bounced back to the accepted level: drop the attempt.
                     state_d = ST_STABLE;
                     cnt_d   = '0;
                  end else if (cnt_q == CNT_LAST) begin
                     sw_bit_d   = sync_s2_q[gi];
                     rise_bit_d = sync_s2_q[gi];
                     fall_bit_d = ~sync_s2_q[gi];
                     state_d    = ST_STABLE;
                     cnt_d      = '0;
                  end else begin
                     cnt_d = cnt_q + NB_COUNT'(1);
                  end
               end
               default: begin
                  state_d = ST_STABLE;
                  cnt_d   = '0;
               end
            endcase
         end

         always_ff @(posedge clock or negedge i_reset) begin
            if (!i_reset) begin
               state_q <= ST_STABLE;
               cnt_q   <= '0;
            end else begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
            end
         end

         assign sw_d[gi]   = sw_bit_d;
         assign rise_d[gi] = rise_bit_d;
         assign fall_d[gi] = fall_bit_d;
      end
   endgenerate

   assign o_sw     = sw_q;
   assign o_rise   = rise_q;
   assign o_fall   = fall_q;
   assign o_change = change_q;

endmodule

// File: tb/tb_sw_debouncer.sv
// -----------------------------------------------------------------------------
// tb_sw_debouncer
//
// Directed scenarios followed by a long random bouncing run on sw_debouncer
// (NB_SW=4, NB_COUNT=3, DB_LIMIT=4). A behavioural model tracks, per bit, how
// many consecutive clock edges the synchronized input has disagreed with the
// debounced level; DB_LIMIT+1 consecutive disagreements accept the new level.
// The model's synchronizer is a plain two-sample delay of i_sw.
// -----------------------------------------------------------------------------
module tb_sw_debouncer;

   localparam int NB_SW    = 4;
   localparam int NB_COUNT = 3;
   localparam int DB_LIMIT = 4;

   logic             clock;
   logic             i_reset;
   logic [NB_SW-1:0] i_sw;
   logic [NB_SW-1:0] o_sw;
   logic [NB_SW-1:0] o_rise;
   logic [NB_SW-1:0] o_fall;
   logic             o_change;

   int checks;
   int errors;

   // Reference model state
   logic [NB_SW-1:0] m_d1;      // i_sw one edge ago
   logic [NB_SW-1:0] m_d2;      // i_sw two edges ago (what the debouncer sees)
   logic [NB_SW-1:0] m_sw;
   logic [NB_SW-1:0] m_rise;
   logic [NB_SW-1:0] m_fall;
   logic             m_change;
   int               m_run [NB_SW];

   sw_debouncer #(
      .NB_SW   (NB_SW),
      .NB_COUNT(NB_COUNT),
      .DB_LIMIT(DB_LIMIT)
   ) dut (
      .clock   (clock),
      .i_reset (i_reset),
      .i_sw    (i_sw),
      .o_sw    (o_sw),
      .o_rise  (o_rise),
      .o_fall  (o_fall),
      .o_change(o_change)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_d1     = '0;
      m_d2     = '0;
      m_sw     = '0;
      m_rise   = '0;
      m_fall   = '0;
      m_change = 1'b0;
      for (int b = 0; b < NB_SW; b++) m_run[b] = 0;
   endtask

   // One clock edge of the model, given the i_sw value present at that edge.
   task automatic model_edge(input logic [NB_SW-1:0] in_now);
      m_rise = '0;
      m_fall = '0;
      for (int b = 0; b < NB_SW; b++) begin
         if (m_d2[b] != m_sw[b]) m_run[b] = m_run[b] + 1;
         else                    m_run[b] = 0;
         if (m_run[b] == DB_LIMIT + 1) begin
            m_sw[b]   = m_d2[b];
            m_rise[b] = m_d2[b];
            m_fall[b] = ~m_d2[b];
            m_run[b]  = 0;
         end
      end
      m_change = |(m_rise | m_fall);
      m_d2 = m_d1;
      m_d1 = in_now;
   endtask

   task automatic compare_model();
      check("o_sw",      32'(o_sw),     32'(m_sw));
      check("o_rise",    32'(o_rise),   32'(m_rise));
      check("o_fall",    32'(o_fall),   32'(m_fall));
      check("o_change",  32'(o_change), 32'(m_change));
      check("rise_and_fall_exclusive", 32'(o_rise & o_fall), 32'd0);
      check("change_is_or_of_pulses",  32'(o_change), 32'(|(o_rise | o_fall)));
   endtask

   // Advance one edge, update the model, compare 1 time unit after the edge.
   task automatic tick();
      logic [NB_SW-1:0] in_now;
      in_now = i_sw;
      @(posedge clock);
      #1;
      if (!i_reset) model_clear();
      else          model_edge(in_now);
      compare_model();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_o_sw"},     32'(o_sw),     32'd0);
      check({tag, "_o_rise"},   32'(o_rise),   32'd0);
      check({tag, "_o_fall"},   32'(o_fall),   32'd0);
      check({tag, "_o_change"}, 32'(o_change), 32'd0);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      i_reset = 1'b1;
      i_sw    = '0;
      model_clear();

      // Power-on reset, asserted between edges: outputs clear without a clock.
      #2;
      i_reset = 1'b0;
      #1;
      check_all_zero("reset_async");
      repeat (2) tick();
      i_reset = 1'b1;

      // Clean step on bit 0: accepted at edge 7, pulse gone at edge 8.
      i_sw = 4'b0001;
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (e == 7) begin
            check("step_o_sw_e7",     32'(o_sw),     32'h1);
            check("step_o_rise_e7",   32'(o_rise),   32'h1);
            check("step_o_change_e7", 32'(o_change), 32'h1);
         end else begin
            check("step_o_rise",   32'(o_rise),   32'h0);
            check("step_o_change", 32'(o_change), 32'h0);
         end
      end
      check("step_o_sw_after", 32'(o_sw), 32'h1);

      // Bounce on bit 1 with a 4-cycle period never qualifies.
      for (int c = 0; c < 50; c++) begin
         if (c < 40) i_sw[1] = ((c / 2) % 2 == 0);
         else        i_sw[1] = 1'b0;
         tick();
         check("bounce_o_sw1",    32'(o_sw[1]),  32'h0);
         check("bounce_o_rise",   32'(o_rise),   32'h0);
         check("bounce_o_fall",   32'(o_fall),   32'h0);
         check("bounce_o_change", 32'(o_change), 32'h0);
      end

      // Bring all switches to 1, then release them all at once.
      i_sw = 4'b1111;
      repeat (10) tick();
      check("all_on_o_sw", 32'(o_sw), 32'hF);
      i_sw = 4'b0000;
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (e == 7) begin
            check("release_o_fall_e7",   32'(o_fall),   32'hF);
            check("release_o_change_e7", 32'(o_change), 32'h1);
         end else begin
            check("release_o_fall", 32'(o_fall), 32'h0);
         end
      end
      check("release_o_sw_after", 32'(o_sw), 32'h0);

      // Late bounce on bit 2: held for 4 edges (counter reaches its last value
      // below acceptance), dropped for one, then held. Only the final hold
      // is accepted, 7 edges after it reaches the input.
      i_sw = 4'b0100;
      for (int e = 0; e < 4; e++) begin
         tick();
         check("late_first_o_rise", 32'(o_rise), 32'h0);
      end
      i_sw = 4'b0000;
      tick();
      check("late_drop_o_rise", 32'(o_rise), 32'h0);
      i_sw = 4'b0100;
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (e == 7) check("late_o_rise_e7", 32'(o_rise), 32'h4);
         else        check("late_o_rise",    32'(o_rise), 32'h0);
      end
      check("late_o_sw_after", 32'(o_sw), 32'h4);

      // Reset while bit 3 is being counted; everything re-qualifies after release.
      i_sw = 4'b1100;
      repeat (4) tick();
      i_reset = 1'b0;
      #1;
      model_clear();
      check_all_zero("midcount_reset");
      repeat (3) tick();
      i_reset = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (e < 7) check("postreset_o_sw_early", 32'(o_sw), 32'h0);
         if (e == 7) begin
            check("postreset_o_sw_e7",   32'(o_sw),   32'hC);
            check("postreset_o_rise_e7", 32'(o_rise), 32'hC);
         end
      end

      // Random bouncing on every bit, checked against the model each edge.
      for (int c = 0; c < 10000; c++) begin
         for (int b = 0; b < NB_SW; b++) begin
            if ($urandom_range(0, 5) == 0) i_sw[b] = ~i_sw[b];
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
